// File: rtl/pc_seq_pkg.sv
// Shared defaults and state encoding for the program-counter sequencer.
// Optional cycle counter is enabled by defining PC_SEQ_CYCLE_CNT_EN.
package pc_seq_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_IDX_W = 5;
  localparam int DEPTH     = 2 ** DEF_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle of pc_sequencer: program control, branch select,
// target-table write port and status outputs.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5
) ();

  logic              Start;
  logic              Halt;
  logic              Branch_en;
  logic [IDX_W-1:0]  Lut_idx;
  logic              Tbl_we;
  logic [IDX_W-1:0]  Tbl_waddr;
  logic [PC_W-1:0]   Tbl_wdata;
  logic [PC_W-1:0]   PC;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [15:0]       Cycle_count;

  modport master (
    output Start, Halt, Branch_en, Lut_idx, Tbl_we, Tbl_waddr, Tbl_wdata,
    input  PC, Busy, Done, Err, Cycle_count
  );

  modport slave (
    input  Start, Halt, Branch_en, Lut_idx, Tbl_we, Tbl_waddr, Tbl_wdata,
    output PC, Busy, Done, Err, Cycle_count
  );

endinterface

// File: rtl/pc_sequencer_target_table.sv
// Branch-target table: register file with one synchronous write port and
// one combinational read port; a same-cycle write is seen only next cycle.
module target_table #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control with table-driven branches.
// Define PC_SEQ_CYCLE_CNT_EN to build the saturating RUN-cycle counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic         Clk,
  input  logic         Reset,
  pc_sequencer_if.slave bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] tbl_rdata;
  logic            tbl_we;

  // Writes during RUN are dropped so a branch never sees a table in flux.
  assign tbl_we = bus.Tbl_we && (state_q != RUN);

  target_table #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_table (
    .clk   (Clk),
    .srst  (Reset),
    .we    (tbl_we),
    .waddr (bus.Tbl_waddr),
    .wdata (bus.Tbl_wdata),
    .raddr (bus.Lut_idx),
    .rdata (tbl_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (bus.Halt)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Halt outranks Branch_en; the increment wraps naturally at 2**PC_W.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (bus.Start) err_d = 1'b0;
      end
      RUN: begin
        if (!bus.Halt) begin
          pc_d = bus.Branch_en ? tbl_rdata : pc_q + 1'b1;
        end
        if (bus.Tbl_we) err_d = 1'b1;
      end
      default: pc_d = '0;
    endcase
  end

  always_comb begin
    bus.PC   = pc_q;
    bus.Busy = (state_q == RUN);
    bus.Done = (state_q == DONE);
    bus.Err  = err_q;
  end

`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && bus.Start) begin
      cyc_d = '0;
    end else if (state_q == RUN && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign bus.Cycle_count = cyc_q;
`else
  assign bus.Cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: the driver queues the expected
// outputs of every cycle, a monitor pops and compares them on the falling edge.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if #(.PC_W(10), .IDX_W(5)) bus ();

  pc_sequencer #(.PC_W(10), .IDX_W(5)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  pc;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cc;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   txn    = 0;

  function automatic logic [15:0] ec(input int v);
`ifdef PC_SEQ_CYCLE_CNT_EN
    return 16'(v);
`else
    return 16'(v - v);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s txn %0d: got 0x%0h expected 0x%0h", name, txn, act, exp_v);
    end
  endtask

  // Monitor: every cycle with a queued expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("[TB] txn %0d pc=%03h busy=%0b done=%0b err=%0b cc=%0d",
                 txn, bus.PC, bus.Busy, bus.Done, bus.Err, bus.Cycle_count);
        chk("pc",   int'(bus.PC),          int'(e.pc));
        chk("busy", int'(bus.Busy),        int'(e.busy));
        chk("done", int'(bus.Done),        int'(e.done));
        chk("err",  int'(bus.Err),         int'(e.err));
        chk("cc",   int'(bus.Cycle_count), int'(e.cc));
      end
    end
  end

  // One clock of stimulus plus the outputs expected after that edge.
  task automatic step(input logic r, input logic st, input logic h, input logic br,
                      input logic [4:0] idx, input logic we, input logic [4:0] wa,
                      input logic [9:0] wd, input logic [9:0] e_pc, input logic e_busy,
                      input logic e_done, input logic e_err, input int e_cc);
    exp_t e;
    rst           = r;
    bus.Start     = st;
    bus.Halt      = h;
    bus.Branch_en = br;
    bus.Lut_idx   = idx;
    bus.Tbl_we    = we;
    bus.Tbl_waddr = wa;
    bus.Tbl_wdata = wd;
    @(posedge clk);
    e.pc = e_pc; e.busy = e_busy; e.done = e_done; e.err = e_err; e.cc = ec(e_cc);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0; bus.Halt = 1'b0; bus.Branch_en = 1'b0; bus.Lut_idx = '0;
    bus.Tbl_we = 1'b0; bus.Tbl_waddr = '0; bus.Tbl_wdata = '0;
    @(negedge clk);

    //   rst st h br idx we wa wdata   pc   bsy dn err cc
    step(1, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
    // table loads in IDLE
    step(0, 0, 0, 0, 0, 1, 3, 10'h016, 10'h000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, 10'h3FF, 10'h000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 10'h0AA, 10'h000, 0, 0, 0, 0);
    // 0,1,2,3 then branch to 0x016, then 0x017 (Start in RUN ignored)
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0, 3);
    step(0, 0, 0, 1, 3, 0, 0, 10'h000, 10'h016, 1, 0, 0, 4);
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h017, 1, 0, 0, 5);
    step(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h017, 0, 1, 0, 6);
    // Start in DONE ignored; Halt/Branch in IDLE ignored
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 6);
    step(0, 0, 1, 1, 3, 0, 0, 10'h000, 10'h000, 0, 0, 0, 6);
    // Halt on 4th RUN cycle -> count 4
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0, 3);
    step(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h003, 0, 1, 0, 4);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 4);
    // Halt and Branch together at PC=5
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0, 0, 4);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h005, 1, 0, 0, 5);
    step(0, 0, 1, 1, 3, 0, 0, 10'h000, 10'h005, 0, 1, 0, 6);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 6);
    // branch to 0x3FF then wrap to 0
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0, 10'h000, 10'h3FF, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 2);
    step(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 1, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 3);
    // write in RUN -> Err, idx 1 keeps 0x0AA; Start clears Err
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 10'h155, 10'h001, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0, 10'h000, 10'h0AA, 1, 0, 1, 2);
    step(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h0AA, 0, 1, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1, 3);
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    // run to PC=7, then Reset (with Halt) wins: no Done, table cleared
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0, 0, 4);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h005, 1, 0, 0, 5);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h006, 1, 0, 0, 6);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h007, 1, 0, 0, 7);
    step(1, 0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 10'h000, 10'h000, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 2);
    step(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h001, 0, 1, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 3);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter and branch-target width.
REQ-002 SHALL have parameter IDX_W, default 5, target-table index width; table depth is 2**IDX_W, 32 entries by default.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begin program execution; sampled only in IDLE.
REQ-006 SHALL have port Halt  input  1  halt instruction decoded this cycle.
REQ-007 SHALL have port Branch_en  input  1  branch taken this cycle.
REQ-008 SHALL have port Lut_idx  input  IDX_W  table index selecting the branch target.
REQ-009 SHALL have port Tbl_we  input  1  target-table write enable.
REQ-010 SHALL have port Tbl_waddr  input  IDX_W  target-table write index.
REQ-011 SHALL have port Tbl_wdata  input  PC_W  target-table write data.
REQ-012 SHALL have port PC  output  PC_W  current instruction address.
REQ-013 SHALL have port Busy  output  1  high in RUN.
REQ-014 SHALL have port Done  output  1  one-cycle pulse on program completion.
REQ-015 SHALL have port Err  output  1  sticky error flag.
REQ-016 SHALL have port Cycle_count  output  16  count of RUN cycles; gated by the configuration macro.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 IDLE SHALL hold PC at 0 with Busy=0; Start=1 SHALL move to RUN on the next edge, and the first RUN cycle SHALL present PC=0.
REQ-019 In RUN, each cycle SHALL apply exactly one action, by priority: Halt -> DONE with PC held; else Branch_en -> PC=table[Lut_idx]; else PC=PC+1.
REQ-020 PC increment SHALL wrap modulo 2**PC_W (1023 -> 0) without raising a flag.
REQ-021 A branch SHALL take effect with latency 1: the target appears on PC the edge after Branch_en is sampled.
REQ-022 The table read SHALL be combinational; a same-cycle write to the indexed entry SHALL NOT be visible to that cycle's branch (old data is used).
REQ-023 Table writes SHALL be accepted only in IDLE or DONE; Tbl_we in RUN SHALL be ignored and SHALL set Err.
REQ-024 DONE SHALL last exactly one cycle with Done=1 and PC holding its final value, then return to IDLE, where PC=0.
REQ-025 Start in RUN or DONE SHALL be ignored; Start in IDLE SHALL clear Err on the same edge it enters RUN.
REQ-026 Halt or Branch_en outside RUN SHALL have no effect.

Reset
REQ-027 Reset SHALL force IDLE with PC=0, Busy=0, Done=0, Err=0, Cycle_count=0, and all table entries=0, on any state.
REQ-028 Reset asserted mid-RUN SHALL abort without a Done pulse; Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-029 With macro PC_SEQ_CYCLE_CNT_EN defined, Cycle_count SHALL increment once per RUN cycle (including the Halt cycle), saturate at 0xFFFF, hold through DONE and IDLE, and clear on Start accepted in IDLE.
REQ-030 Without PC_SEQ_CYCLE_CNT_EN, Cycle_count SHALL be constant 0, with no counter registers inferred.

Structure
REQ-031 Package pc_seq_pkg SHALL hold PC_W/IDX_W defaults, DEPTH constant and the state enum typedef (IDLE, RUN, DONE).
REQ-032 Table storage SHALL be sub-module target_table: 2**IDX_W x PC_W registers, one synchronous write port, one combinational read port, synchronous reset to 0.

Verification
REQ-033 Write idx 3=0x016, Start, run 3 cycles, Branch_en idx 3 -> PC sequence 0,1,2,3,0x016, then 0x017.
REQ-034 Halt and Branch_en asserted together at PC=5 -> PC stays 5, Done=1 for exactly one cycle, then IDLE with PC=0.
REQ-035 Branch to an entry holding 0x3FF, then no branch -> PC 0x3FF then 0x000, Err stays 0.
REQ-036 Tbl_we in RUN to idx 1 -> Err=1 and idx 1 unchanged; next Start in IDLE -> Err=0.
REQ-037 Reset pulsed at PC=7 in RUN -> next cycle PC=0, Busy=0, no Done pulse, table read as 0.
REQ-038 With PC_SEQ_CYCLE_CNT_EN defined, Start then Halt on the 4th RUN cycle -> Cycle_count=4; rebuild without the macro -> Cycle_count=0 throughout.
